// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

    // Header bytes (LEN_HI, LEN_LO) preceding the payload.
    localparam int HDR_LEN = 2;

    function automatic logic takes_bytes(input state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU status of the loader.
interface instr_mem_loader_if #(parameter int ADDR_W = 5);
    logic              start_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              cpu_rst_o;
    logic              done_o;
    logic              err_o;
    logic [15:0]       word_cnt_o;

    modport slave (
        input  start_i, byte_i, byte_valid_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
               cpu_rst_o, done_o, err_o, word_cnt_o
    );

    modport master (
        output start_i, byte_i, byte_valid_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
               cpu_rst_o, done_o, err_o, word_cnt_o
    );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; word_full marks the 4th byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_full,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] shift;

    // The word completes combinationally with the 4th byte so it can be registered in one step.
    assign word_full = take && (cnt == 2'd3);
    assign word      = {shift, data};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shift <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shift <= '0;
        end else if (take) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[15:0], data};
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length-framed, XOR-checked image and writes it to instruction memory.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input logic               clk_i,
    input logic               rst_i,
    instr_mem_loader_if.slave bus
);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [15:0] word_cnt;
    logic [7:0]  csum;
    logic [15:0] len_rx;
    logic        take, start_ok, pack_take, word_full;
    logic [31:0] packed_word;

    assign take      = bus.byte_valid_i && bus.byte_ready_o;
    assign start_ok  = bus.start_i && (state inside {IDLE, DONE, ERROR});
    assign pack_take = take && (state == S_DATA);
    assign len_rx    = {len_hi, bus.byte_i};

    assign bus.byte_ready_o = takes_bytes(state);
    assign bus.done_o       = (state == DONE);
    assign bus.cpu_rst_o    = (state == DONE);
    assign bus.err_o        = (state == ERROR);
    assign bus.word_cnt_o   = word_cnt;

    byte_packer u_packer (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .clear     (start_ok),
        .take      (pack_take),
        .data      (bus.byte_i),
        .word_full (word_full),
        .word      (packed_word)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (bus.start_i) state_nxt = S_LEN_HI;
            S_LEN_HI:          if (take) state_nxt = S_LEN_LO;
            S_LEN_LO: if (take) begin
                if ({1'b0, len_rx} > MAX_WORDS) state_nxt = ERROR;
                else if (len_rx == 16'd0)       state_nxt = S_CSUM;
                else                            state_nxt = S_DATA;
            end
            S_DATA: if (word_full && (word_idx + 16'd1 == len)) state_nxt = S_CSUM;
            S_CSUM: if (take) state_nxt = (bus.byte_i == csum) ? DONE : ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    // Write strobe is registered; word_cnt trails it by one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len_hi          <= '0;
            len             <= '0;
            word_idx        <= '0;
            word_cnt        <= '0;
            csum            <= '0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            bus.mem_we_o <= word_full;
            if (word_full) begin
                bus.mem_addr_o  <= word_idx[ADDR_W-1:0];
                bus.mem_wdata_o <= packed_word;
            end
            if (start_ok) begin
                word_idx <= '0;
                word_cnt <= '0;
                csum     <= '0;
            end else begin
                if (word_full)    word_idx <= word_idx + 16'd1;
                if (bus.mem_we_o) word_cnt <= word_cnt + 16'd1;
                if (pack_take)    csum     <= csum ^ bus.byte_i;
            end
            if (take && state == S_LEN_HI) len_hi <= bus.byte_i;
            if (take && state == S_LEN_LO) len    <= len_rx;
        end
    end
endmodule
